disp_sched_loader: RTL
======================

DISP_SCHED_LOADER -- requirements
Module: disp_sched_loader

Interface
REQ-001 SHALL have parameter DISP_W, default 16: width of the display-control value.
REQ-002 SHALL have parameter TIME_W, default 32: width of the cycle counter and entry start cycle.
REQ-003 SHALL have parameter DEPTH, default 8, power of two: schedule FIFO depth.
REQ-004 SHALL have port Clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port notReset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port EntryValid  in  1  schedule entry offered.
REQ-007 SHALL have port EntryReady  out  1  entry accepted when EntryValid and EntryReady are both high at a rising edge.
REQ-008 SHALL have port EntryDisp  in  DISP_W  display value to apply.
REQ-009 SHALL have port EntryCycle  in  TIME_W  binary cycle number at which to apply it.
REQ-010 SHALL have port Flush  in  1  discard all pending entries.
REQ-011 SHALL have port DispValOut  out  DISP_W  currently applied display-control value.
REQ-012 SHALL have port CycleCount  out  TIME_W  cycles since reset.
REQ-013 SHALL have port Pending  out  log2(DEPTH)+1  number of queued entries.
REQ-014 SHALL have port Applied  out  1  one-cycle pulse on each DispValOut update.
REQ-015 SHALL have port Late  out  1  one-cycle pulse when an applied entry's EntryCycle < CycleCount at the apply edge.

Function
REQ-016 CycleCount SHALL increment by 1 every cycle after reset release, saturating at all-ones (no wrap).
REQ-017 EntryReady SHALL be high iff Pending < DEPTH and Flush is low; it SHALL NOT depend on a same-cycle pop.
REQ-018 Accepted entries SHALL be queued in FIFO order; no reordering by EntryCycle.
REQ-019 FSM states: EMPTY (Pending=0), WAIT (head queued, CycleCount < head cycle), FIRE (CycleCount >= head cycle).
REQ-020 In FIRE, at the edge, DispValOut SHALL load head EntryDisp, head SHALL pop, Applied SHALL pulse next cycle; at most one entry applied per cycle.
REQ-021 Next state after FIRE: EMPTY if Pending becomes 0, else FIRE or WAIT per comparison against the new head.
REQ-022 An entry pushed into an empty FIFO SHALL be compared from the following cycle: earliest DispValOut change is 2 edges after acceptance.
REQ-023 An entry whose EntryCycle has already passed SHALL still be applied (immediately) with Late asserted.
REQ-024 Push and pop in the same cycle SHALL leave Pending unchanged.
REQ-025 Flush SHALL zero Pending next edge, suppress any same-cycle push and apply, hold DispValOut and not affect CycleCount; state goes to EMPTY.
REQ-026 Comparisons SHALL be unsigned, TIME_W bits wide.

Reset
REQ-027 On notReset low: DispValOut=0, CycleCount=0, Pending=0, Applied=0, Late=0, FIFO pointers 0, state EMPTY; EntryReady=0 while reset asserted.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries immediately; no partial apply.

Structure
REQ-029 State encoding and DEPTH/DISP_W/TIME_W defaults SHALL live in the shared test-harness definitions header alongside the existing display-control widths.
REQ-030 The FIFO SHALL be a separate sub-module disp_sched_fifo (DEPTH entries of DISP_W+TIME_W, full/empty/count).

Verification
REQ-031 Push (0x0003, cycle 10) at cycle 2 -> DispValOut=0x0003 from cycle 11, Applied pulse once, Late=0.
REQ-032 Push (0x00F0, cycle 1) at cycle 5 -> applied 2 edges after acceptance, Late pulses.
REQ-033 Push 8 entries, 9th offered -> EntryReady=0, Pending=8; after first apply EntryReady=1 next cycle.
REQ-034 Entries (0x1,20),(0x2,20),(0x3,20) -> applied on three consecutive cycles from 20, final value 0x3.
REQ-035 Queue 4 entries, Flush at cycle 15 with EntryValid high -> Pending=0, DispValOut unchanged, pushed entry dropped.
REQ-036 Assert notReset low mid-WAIT for 1 cycle -> all outputs 0, CycleCount restarts at 0.

Source files
------------

// File: rtl/disp_sched_loader_pkg.sv
// Shared definitions for the display-control schedule loader: default widths,
// FIFO depth and the scheduler state encoding.
package disp_sched_loader_pkg;

   localparam int DISP_W_DEF = 16;
   localparam int TIME_W_DEF = 32;
   localparam int DEPTH_DEF  = 8;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FIRE  = 2'd2
   } sched_state_e;

endpackage

// File: rtl/disp_sched_loader_fifo.sv
// Schedule entry FIFO: DEPTH entries of {disp, cycle}, with head and the entry
// behind the head visible so the scheduler can look one entry ahead when it pops.
module disp_sched_fifo #(
   parameter int DISP_W = 16,
   parameter int TIME_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [DISP_W+TIME_W-1:0]   wdata_i,
   output logic [DISP_W+TIME_W-1:0]   head_o,
   output logic [TIME_W-1:0]          head_next_cycle_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DISP_W + TIME_W;

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] rd_ptr_nxt;
   logic [AW:0]   count_q, count_d;
   logic [EW-1:0] head_next;
   logic          do_push, do_pop;

   assign full_o            = (count_q == (AW+1)'(DEPTH));
   assign empty_o           = (count_q == '0);
   assign count_o           = count_q;
   assign do_push           = push_i & ~full_o & ~flush_i;
   assign do_pop            = pop_i & ~empty_o & ~flush_i;
   assign rd_ptr_nxt        = rd_ptr_q + AW'(1);
   assign head_o            = mem_q[rd_ptr_q];
   assign head_next         = mem_q[rd_ptr_nxt];
   assign head_next_cycle_o = head_next[TIME_W-1:0];

   // Pointer and occupancy update; flush clears everything and blocks push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_nxt;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/disp_sched_loader.sv
// Display-control schedule loader: queues {value, cycle} entries and applies
// each value to DispValOut once the free-running cycle counter reaches it.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_EMPTY | nothing queued (or head just arrived, compared next cycle)
//   ST_WAIT  | head queued, CycleCount still below head cycle
//   ST_FIRE  | CycleCount >= head cycle; head applied and popped this edge
//
// The state for the next cycle is chosen against the next CycleCount value,
// so being in ST_FIRE always means CycleCount >= head cycle during that cycle.
module disp_sched_loader
   import disp_sched_loader_pkg::*;
#(
   parameter int DISP_W = DISP_W_DEF,
   parameter int TIME_W = TIME_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                     Clk,
   input  logic                     notReset,
   input  logic                     EntryValid,
   output logic                     EntryReady,
   input  logic [DISP_W-1:0]        EntryDisp,
   input  logic [TIME_W-1:0]        EntryCycle,
   input  logic                     Flush,
   output logic [DISP_W-1:0]        DispValOut,
   output logic [TIME_W-1:0]        CycleCount,
   output logic [$clog2(DEPTH):0]   Pending,
   output logic                     Applied,
   output logic                     Late
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = DISP_W + TIME_W;

   sched_state_e       state_q, state_d;
   logic [DISP_W-1:0]  disp_q, disp_d;
   logic [TIME_W-1:0]  cnt_q, cnt_d;
   logic               applied_q, applied_d;
   logic               late_q, late_d;

   logic               push, pop;
   logic [EW-1:0]      head;
   logic [DISP_W-1:0]  head_disp;
   logic [TIME_W-1:0]  head_cycle;
   logic [TIME_W-1:0]  head_next_cycle;
   logic               fifo_full, fifo_empty;
   logic [AW:0]        fifo_count;
   logic               cmp_valid;
   logic [TIME_W-1:0]  cmp_cycle;

   // Ready is deliberately independent of a same-cycle pop.
   assign EntryReady = notReset & ~fifo_full & ~Flush;
   assign push       = EntryValid & EntryReady;
   assign head_disp  = head[TIME_W +: DISP_W];
   assign head_cycle = head[TIME_W-1:0];

   // Free-running cycle counter that sticks at all-ones.
   assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + TIME_W'(1);

   disp_sched_fifo #(
      .DISP_W (DISP_W),
      .TIME_W (TIME_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk_i             (Clk),
      .rst_ni            (notReset),
      .flush_i           (Flush),
      .push_i            (push),
      .pop_i             (pop),
      .wdata_i           ({EntryDisp, EntryCycle}),
      .head_o            (head),
      .head_next_cycle_o (head_next_cycle),
      .full_o            (fifo_full),
      .empty_o           (fifo_empty),
      .count_o           (fifo_count)
   );

   // Next-state, apply and pop decision. After a pop the next head is the
   // entry behind it, or the entry being pushed if the FIFO held only one.
   always_comb begin
      state_d   = state_q;
      disp_d    = disp_q;
      applied_d = 1'b0;
      late_d    = 1'b0;
      pop       = 1'b0;
      cmp_valid = 1'b0;
      cmp_cycle = head_cycle;
      if (Flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY, ST_WAIT: begin
               cmp_valid = ~fifo_empty;
               cmp_cycle = head_cycle;
            end
            ST_FIRE: begin
               pop       = 1'b1;
               disp_d    = head_disp;
               applied_d = 1'b1;
               late_d    = (head_cycle < cnt_q);
               if (fifo_count > (AW+1)'(1)) begin
                  cmp_valid = 1'b1;
                  cmp_cycle = head_next_cycle;
               end else if (push) begin
                  cmp_valid = 1'b1;
                  cmp_cycle = EntryCycle;
               end
            end
            default: begin
               cmp_valid = 1'b0;
            end
         endcase
         if (!cmp_valid) begin
            state_d = ST_EMPTY;
         end else if (cnt_d >= cmp_cycle) begin
            state_d = ST_FIRE;
         end else begin
            state_d = ST_WAIT;
         end
      end
   end

   // Scheduler state, applied value, counter and pulse registers.
   always_ff @(posedge Clk or negedge notReset) begin
      if (!notReset) begin
         state_q   <= ST_EMPTY;
         disp_q    <= '0;
         cnt_q     <= '0;
         applied_q <= 1'b0;
         late_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         disp_q    <= disp_d;
         cnt_q     <= cnt_d;
         applied_q <= applied_d;
         late_q    <= late_d;
      end
   end

   assign DispValOut = disp_q;
   assign CycleCount = cnt_q;
   assign Pending    = fifo_count;
   assign Applied    = applied_q;
   assign Late       = late_q;

endmodule
